adc_chain_sequencer: RTL and testbench

//  Sequences a chain of adc_channels ADC deserializer/output-register stages.
//  On each sample trigger it generates the ADC serial clock and shift enables,

---
 rtl/adc_chain_sequencer.sv | 132 +++++++++++++
 tb/tb_adc_chain_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_chain_sequencer.sv
// Readout sequencer for a chain of ADC deserializer stages: generates the serial
// clock and shift enables, parallel-loads the chain, then drains it word by word.
module adc_chain_sequencer #(
    parameter int adc_bits     = 24,
    parameter int adc_channels = 8,
    parameter int sck_div      = 4,
    localparam int IW = (adc_channels > 1) ? $clog2(adc_channels) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          sample_trigger,
    output logic          adc_sck,
    output logic          shift_ena,
    output logic          shifter_load_ena,
    output logic          ext_load_ena,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [IW-1:0] word_index,
    output logic          word_last,
    output logic          busy,
    output logic          overrun,
    input  logic          overrun_clear
);
    localparam int PW = (sck_div > 1) ? $clog2(sck_div) : 1;
    localparam int BW = $clog2(adc_bits + 1);
    localparam int WW = $clog2(adc_channels + 1);

    localparam logic [PW-1:0] PH_LAST  = PW'(sck_div - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(sck_div / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(adc_bits - 1);
    localparam logic [WW-1:0] N_WORDS  = WW'(adc_channels);
    localparam logic [IW-1:0] IDX_LAST = IW'(adc_channels - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]   words_left_q, words_left_d;
    logic [IW-1:0]   word_index_q, word_index_d;
    logic            overrun_q, overrun_d;
    logic            set_ovr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            word_index_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            words_left_q <= words_left_d;
            word_index_q <= word_index_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        bit_cnt_d        = bit_cnt_q;
        words_left_d     = words_left_q;
        word_index_d     = word_index_q;
        overrun_d        = overrun_q;
        set_ovr          = 1'b0;
        adc_sck          = 1'b0;
        shift_ena        = 1'b0;
        shifter_load_ena = 1'b0;

        // Drain side runs independently of the shift FSM.
        word_valid   = (words_left_q != '0);
        word_last    = (words_left_q == WW'(1));
        ext_load_ena = word_valid && word_ready;
        busy         = (state_q != IDLE);

        if (ext_load_ena) begin
            words_left_d = words_left_q - 1'b1;
            if (word_index_q != IDX_LAST)
                word_index_d = word_index_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sample_trigger) begin
                    state_d   = SHIFT;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                adc_sck = (phase_q < PH_HALF);
                if (phase_q == PH_LAST) begin
                    shift_ena = 1'b1;
                    phase_d   = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST)
                        state_d = LOAD;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = IDLE;
                // A load needs an empty chain, so no transfer can coincide with it.
                if (words_left_q == '0) begin
                    shifter_load_ena = 1'b1;
                    words_left_d     = N_WORDS;
                    word_index_d     = '0;
                end else begin
                    set_ovr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample_trigger && state_q != IDLE)
            set_ovr = 1'b1;

        if (set_ovr)
            overrun_d = 1'b1;
        else if (overrun_clear)
            overrun_d = 1'b0;
    end

    assign word_index = word_index_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_chain_sequencer.sv
// Bench for adc_chain_sequencer: models the stage chain and ADC data, and
// scoreboards every drained word against the samples that were triggered.
module tb_adc_chain_sequencer;
    localparam int BITS = 24;
    localparam int CH   = 8;
    localparam int DIV  = 4;

    typedef struct packed {
        logic [2:0]      idx;
        logic            last;
        logic [BITS-1:0] data;
    } exp_t;

    logic       clock, reset_n, sample_trigger, word_ready, overrun_clear;
    logic       adc_sck, shift_ena, shifter_load_ena, ext_load_ena;
    logic       word_valid, word_last, busy, overrun;
    logic [2:0] word_index;

    adc_chain_sequencer #(.adc_bits(BITS), .adc_channels(CH), .sck_div(DIV)) dut (
        .clock(clock), .reset_n(reset_n), .sample_trigger(sample_trigger),
        .adc_sck(adc_sck), .shift_ena(shift_ena), .shifter_load_ena(shifter_load_ena),
        .ext_load_ena(ext_load_ena), .word_valid(word_valid), .word_ready(word_ready),
        .word_index(word_index), .word_last(word_last), .busy(busy),
        .overrun(overrun), .overrun_clear(overrun_clear)
    );

    int   n_vec = 0, n_err = 0, cyc = 0, n_xfer = 0, n_ext = 0, t0 = 0;
    exp_t sb[$];
    logic [BITS-1:0] samp [CH];
    logic [BITS-1:0] shf  [CH];
    logic [BITS-1:0] oreg [CH];
    int   sbit = 0;
    logic hold_q = 1'b0;
    logic [2:0] hold_idx;
    logic [BITS-1:0] hold_data;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stage chain and ADCs: each ADC presents its sample MSB first.
    always @(posedge clock) begin
        if (!busy) sbit <= 0;
        else if (shift_ena) sbit <= sbit + 1;
        for (int i = 0; i < CH; i++) begin
            if (shift_ena) shf[i] <= {shf[i][BITS-2:0], samp[i][BITS-1-sbit]};
            if (shifter_load_ena) oreg[i] <= shf[i];
            else if (ext_load_ena) oreg[i] <= (i == 0) ? '0 : oreg[i-1];
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            exp_t e;
            chk("ext_load", ext_load_ena, word_valid && word_ready);
            chk("both_load", shifter_load_ena && ext_load_ena, 0);
            if (hold_q) begin
                chk("hold_vld", word_valid, 1);
                chk("hold_idx", word_index, hold_idx);
                chk("hold_data", oreg[CH-1], hold_data);
            end
            if (ext_load_ena) n_ext++;
            if (word_valid && word_ready) begin
                chk("sb_avail", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("word_idx", word_index, e.idx);
                    chk("word_last", word_last, e.last);
                    chk("word_data", oreg[CH-1], e.data);
                end
                n_xfer++;
            end
            hold_q    = word_valid && !word_ready;
            hold_idx  = word_index;
            hold_data = oreg[CH-1];
        end else begin
            hold_q = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic at_cyc(input int c);
        goto_cyc(c);
        @(negedge clock);
    endtask

    // starts: trigger reaches an idle FSM; loads: its LOAD finds the chain empty.
    task automatic trig(input bit starts, input bit loads);
        exp_t e;
        sample_trigger = 1'b1;
        t0 = cyc;
        if (starts)
            for (int i = 0; i < CH; i++) samp[i] = BITS'($urandom());
        if (loads)
            for (int k = 0; k < CH; k++) begin
                e.idx  = 3'(k);
                e.last = (k == CH - 1);
                e.data = samp[CH-1-k];
                sb.push_back(e);
            end
        step();
        sample_trigger = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {adc_sck, shift_ena, shifter_load_ena, ext_load_ena, word_valid,
                  word_index, word_last, busy, overrun}, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk_all_zero("reset_outs");
        sb.delete();
        @(negedge clock);
        step();
        reset_n = 1'b1;
    endtask

    task automatic drain_wait(input string tag, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) step();
        chk(tag, sb.size(), 0);
    endtask

    task automatic run_t1(input string tag);
        int t, last, n_sh, n_sck, e0;
        word_ready = 1'b1;
        e0 = n_ext;
        trig(1, 1);
        t = t0; last = t0; n_sh = 0; n_sck = 0;
        for (int c = t + 1; c <= t + 96; c++) begin
            at_cyc(c);
            chk({tag, "_sck"}, adc_sck, ((c - t - 1) % DIV) < DIV / 2);
            if (adc_sck) n_sck++;
            if (shift_ena) begin
                chk({tag, "_shift_gap"}, cyc - last, DIV);
                last = cyc;
                n_sh++;
            end
        end
        at_cyc(t + 97);
        chk({tag, "_load"}, shifter_load_ena, 1);
        chk({tag, "_busy97"}, busy, 1);
        chk({tag, "_nshift"}, n_sh, BITS);
        chk({tag, "_nsck"}, n_sck, BITS * DIV / 2);
        at_cyc(t + 98);
        chk({tag, "_busy98"}, busy, 0);
        chk({tag, "_valid98"}, word_valid, 1);
        at_cyc(t + 106);
        chk({tag, "_valid_end"}, word_valid, 0);
        chk({tag, "_n_ext"}, n_ext - e0, CH);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int t, x0;
        reset_n = 1'b1; sample_trigger = 1'b0; word_ready = 1'b0; overrun_clear = 1'b0;
        #1 reset_n = 1'b0;
        #1 chk_all_zero("por_outs");
        step();
        reset_n = 1'b1;
        step();

        // T1
        run_t1("t1");

        // T2: ready one cycle on, two off
        word_ready = 1'b0;
        x0 = n_xfer;
        trig(1, 1);
        for (int k = 0; k < 150; k++) begin
            step();
            word_ready = (cyc % 3 == 0);
        end
        chk("t2_xfers", n_xfer - x0, CH);
        chk("t2_sb_empty", sb.size(), 0);

        // T3: stalled consumer, second sample dropped
        word_ready = 1'b0;
        trig(1, 1);
        t = t0;
        goto_cyc(t + 200);
        trig(1, 0);
        t = t0;
        at_cyc(t + 97);
        chk("t3_noload", shifter_load_ena, 0);
        at_cyc(t + 98);
        chk("t3_ovr", overrun, 1);
        chk("t3_valid", word_valid, 1);
        chk("t3_idx", word_index, 0);
        chk("t3_last", word_last, 0);
        step();
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        @(negedge clock);
        chk("t3_ovr_clr", overrun, 0);
        word_ready = 1'b1;
        drain_wait("t3_drain", 40);

        // T4: trigger during SHIFT is ignored
        trig(1, 1);
        t = t0;
        goto_cyc(t + 10);
        trig(0, 0);
        @(negedge clock);
        chk("t4_ovr", overrun, 1);
        goto_cyc(t + 50);
        overrun_clear = 1'b1;
        trig(0, 0);
        overrun_clear = 1'b0;
        @(negedge clock);
        chk("t4_set_wins", overrun, 1);
        at_cyc(t + 97);
        chk("t4_load", shifter_load_ena, 1);
        drain_wait("t4_drain", 40);
        step();
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        @(negedge clock);
        chk("t4_ovr_clr", overrun, 0);

        // T5: next trigger while three words remain
        x0 = n_xfer;
        trig(1, 1);
        t = t0;
        goto_cyc(t + 103);
        trig(1, 1);
        t = t0;
        at_cyc(t + 97);
        chk("t5_load", shifter_load_ena, 1);
        drain_wait("t5_drain", 40);
        @(negedge clock);
        chk("t5_ovr", overrun, 0);
        chk("t5_xfers", n_xfer - x0, 2 * CH);

        // T6: reset mid-SHIFT, then mid-drain
        word_ready = 1'b0;
        trig(1, 1);
        t = t0;
        goto_cyc(t + 30);
        do_reset();
        for (int k = 0; k < 120; k++) begin
            @(negedge clock);
            chk("t6_quiet_a", {adc_sck, shift_ena, shifter_load_ena, ext_load_ena, word_valid}, 0);
        end
        step();
        trig(1, 1);
        t = t0;
        goto_cyc(t + 100);
        word_ready = 1'b1;
        goto_cyc(t + 103);
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk("t6_quiet_b", {adc_sck, shift_ena, shifter_load_ena, ext_load_ena, word_valid}, 0);
        end
        step();
        run_t1("t6_clean");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
